// File: rtl/cache_pkg.sv
// Shared definitions for the cache backing-store responder.
// Holds the responder FSM encoding, address-slicing constants and the default word width.
package cache_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH     = 32;
   localparam int unsigned BYTE_OFF_BITS  = 2;
   localparam int unsigned CNT_WIDTH      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

endpackage

// File: rtl/cache_mem_responder_mem_array.sv
// Word RAM: synchronous write, combinational read, single shared address port.
// Ports: clk; we/addr/wdata write side; rdata_c combinational read of mem[addr].
module mem_array #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MEM_ADDR_BITS = 10
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [MEM_ADDR_BITS-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic [DATA_WIDTH-1:0]    rdata_c
);

   localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata_c = mem[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Backing-store responder for the direct-mapped data cache.
// Accepts one read/write request, waits LATENCY cycles, then returns data or a write ack.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata request
// channel; resp_valid/resp_ready/resp_rdata/resp_we response channel.
module cache_mem_responder
   import cache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int unsigned MEM_ADDR_BITS = 10,
   parameter int unsigned LATENCY       = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_we
);

   localparam int unsigned IDX_LSB = BYTE_OFF_BITS;
   localparam int unsigned IDX_MSB = MEM_ADDR_BITS + BYTE_OFF_BITS - 1;

   resp_state_t              state_q, state_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [MEM_ADDR_BITS-1:0] idx_q, idx_d;
   logic                     we_q, we_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     req_ready_d;
   logic                     resp_valid_d;
   logic [DATA_WIDTH-1:0]    resp_rdata_d;
   logic                     resp_we_d;

   logic [MEM_ADDR_BITS-1:0] req_idx_c;
   logic [MEM_ADDR_BITS-1:0] mem_addr_c;
   logic                     mem_we_c;
   logic [DATA_WIDTH-1:0]    mem_rdata_c;
   logic                     accept_c;
   logic                     unused_addr_bits_c;

   // Upper and byte-offset address bits alias away.
   assign req_idx_c          = req_addr[IDX_MSB:IDX_LSB];
   assign unused_addr_bits_c = ^{req_addr[ADDR_WIDTH-1:IDX_MSB+1], req_addr[IDX_LSB-1:0]};
   assign accept_c           = req_valid && req_ready;

   mem_array #(
      .DATA_WIDTH    (DATA_WIDTH),
      .MEM_ADDR_BITS (MEM_ADDR_BITS)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we_c),
      .addr    (mem_addr_c),
      .wdata   (req_wdata),
      .rdata_c (mem_rdata_c)
   );

   // Next-state, counter and response-register logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      req_ready_d  = req_ready;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_we_d    = resp_we;
      mem_addr_c   = idx_q;
      mem_we_c     = 1'b0;

      case (state_q)
         IDLE: begin
            // RAM port follows the live request so writes commit at acceptance.
            mem_addr_c = req_idx_c;
            if (accept_c) begin
               idx_d       = req_idx_c;
               we_d        = req_we;
               wdata_d     = req_wdata;
               mem_we_c    = req_we;
               cnt_d       = CNT_WIDTH'(LATENCY - 1);
               req_ready_d = 1'b0;
               if (LATENCY == 1) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_we_d    = req_we;
                  resp_rdata_d = req_we ? req_wdata : mem_rdata_c;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_we_d    = we_q;
               resp_rdata_d = we_q ? wdata_q : mem_rdata_c;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_we    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_we    <= resp_we_d;
      end
   end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Backing-store responder on the far side of the direct-mapped data cache.
- Accepts one read-refill or write-through request at a time over a valid/ready handshake.
- Models a word-addressed data memory with a fixed, configurable access latency, then returns the read data or a write acknowledge over a second valid/ready handshake.
- Gives the cache a realistic miss penalty instead of a same-cycle data source.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- MEM_ADDR_BITS, 10, log2 of memory depth in words (1024 words).
- LATENCY, 3, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  cache presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write-through, 0 = read refill.
- req_addr  input  32  byte address; word index is req_addr[MEM_ADDR_BITS+1:2].
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  cache consumes the response.
- resp_rdata  output  DATA_WIDTH  read data, or echoed write data for writes.
- resp_we  output  1  response belongs to a write.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_we = 0, latency counter = 0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid && req_ready, the request is accepted. Register the word index, req_we and req_wdata.
  - If req_we = 1, write mem[index] <= req_wdata on that same edge.
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY = 1, else go to WAIT.
- WAIT:
  - req_ready = 0.
  - Decrement the counter each edge.
  - When the counter equals 1, go to RESP on that edge.
- On the edge that enters RESP:
  - resp_rdata <= mem[index] for a read, or the registered wdata for a write.
  - resp_we <= registered we.
  - resp_valid <= 1.
- Net latency: acceptance at edge t gives resp_valid high in the cycle following edge t+LATENCY-1, which is exactly LATENCY cycles after acceptance.
- RESP:
  - req_ready = 0.
  - resp_valid, resp_rdata and resp_we are held stable until resp_ready = 1 at a rising edge.
  - On that edge, resp_valid <= 0 and go to IDLE.
- No same-cycle response-to-request overlap. The next request can be accepted at the earliest one cycle after the response handshake.
- req_addr bits above MEM_ADDR_BITS+1 and bits [1:0] are ignored; addresses alias (wrap) modulo the memory depth.
- Request inputs are ignored while req_ready = 0. The cache must hold req_* stable until accepted.
- Read-after-write to the same word returns the new data, since the write commits at acceptance.
- Reset mid-operation (WAIT or RESP):
  - The in-flight response is discarded and the FSM returns to IDLE.
  - A write already accepted remains committed.
- resp_ready while resp_valid = 0 has no effect.
- Single outstanding request; no reordering.

Decomposition:
- Shared package cache_pkg holds:
  - enum resp_state_t {IDLE, WAIT, RESP};
  - localparams for word-index extraction (byte-offset width 2);
  - DATA_WIDTH default.
- Natural sub-module: mem_array, a single-port synchronous-write, combinational-read word RAM parameterised by DATA_WIDTH and MEM_ADDR_BITS.
- The FSM, counter and response registers stay in cache_mem_responder.

Test Plan:
- Reset with rst = 0 mid-WAIT, release -> req_ready = 1, resp_valid = 0, resp_rdata = 0 on the first cycle after release.
- LATENCY = 3: write addr 0x0000_0010, data 0xDEAD_BEEF, resp_ready = 1 -> resp_valid high exactly 3 cycles after acceptance, resp_we = 1, resp_rdata = 0xDEAD_BEEF.
- Then read addr 0x0000_0010 -> 3 cycles later resp_valid = 1, resp_we = 0, resp_rdata = 0xDEAD_BEEF.
- Backpressure: read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready = 0; handshake on cycle 6, then req_ready = 1 on the next cycle.
- Aliasing (MEM_ADDR_BITS = 10): write 0x1234_5678 to 0x0000_1004, read 0x0000_0004 -> resp_rdata = 0x1234_5678.
- LATENCY = 1: back-to-back reads with resp_ready tied 1 -> resp_valid one cycle after each acceptance, one request accepted every 2 cycles, data matches prior writes.
